// File: rtl/dist_pkg.sv
// Shared types and constants for the byte distributor scheduler.
package dist_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic {
    StIdle,
    StSend
  } state_e;

endpackage

// File: rtl/dist_rr_pick.sv
// Combinational round-robin picker: first set mask bit searching upward from ptr+1 (mod NUM_CH).
module dist_rr_pick
  import dist_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   target,
  output logic              any
);

  logic [CH_W-1:0] idx;

  // Scan the NUM_CH candidates in priority order; the first hit wins.
  always_comb begin
    target = '0;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = ptr + CH_W'(i);
      if (!any && mask[idx]) begin
        target = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dist_scheduler.sv
// Scheduler in front of the 4-way byte distributor. Holds one beat at a time, picks its
// channel (round-robin over ch_mask or fixed), and drives the distributor from registers.
// Optional statistics counters are enabled by defining DIST_SCHED_STATS_EN.
module dist_scheduler
  import dist_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              sched_mode,
  input  logic [CH_W-1:0]   fixed_ch,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] ch_ready,
  output logic              dist_enable,
  output logic [CH_W-1:0]   dist_select,
  output logic [DATA_W-1:0] dist_data,
  output logic              drop_pulse,
  output logic              busy
`ifdef DIST_SCHED_STATS_EN
  ,
  input  logic [CH_W-1:0]   stat_ch,
  output logic [15:0]       stat_count,
  output logic [15:0]       stat_drops
`endif
);

  localparam logic [7:0] ToLast = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_e            state_q;
  logic [DATA_W-1:0] data_q;
  logic [CH_W-1:0]   tgt_q;
  logic [CH_W-1:0]   rr_ptr_q;
  logic [7:0]        cnt_q;

  logic [CH_W-1:0]   rr_target;
  logic              rr_any;
  logic              exists;
  logic              tgt_ready;
  logic              accept;
  logic              deliver;
  logic              timeout_hit;
  logic [CH_W-1:0]   next_tgt;

  dist_rr_pick u_rr_pick (
    .mask   (ch_mask),
    .ptr    (rr_ptr_q),
    .target (rr_target),
    .any    (rr_any)
  );

  // Handshake and decision terms for the current cycle.
  always_comb begin
    exists      = (sched_mode == MODE_FIXED) || rr_any;
    tgt_ready   = ch_ready[tgt_q];
    deliver     = (state_q == StSend) && tgt_ready;
    in_ready    = 1'b0;
    if (rst_n) begin
      in_ready = (state_q == StIdle) ? exists : (tgt_ready && exists);
    end
    accept      = in_valid && in_ready;
    next_tgt    = (sched_mode == MODE_FIXED) ? fixed_ch : rr_target;
    // Ready on the last allowed cycle takes priority over the drop.
    timeout_hit = (TIMEOUT != 0) && (state_q == StSend) && !tgt_ready && (cnt_q == ToLast);
  end

  assign dist_select = tgt_q;
  assign dist_data   = data_q;

  // Beat-holding FSM with registered distributor controls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      data_q      <= '0;
      tgt_q       <= '0;
      rr_ptr_q    <= CH_W'(NUM_CH - 1);
      cnt_q       <= '0;
      dist_enable <= 1'b0;
      drop_pulse  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q     <= StSend;
            data_q      <= in_data;
            tgt_q       <= next_tgt;
            cnt_q       <= '0;
            dist_enable <= 1'b1;
            busy        <= 1'b1;
            if (sched_mode == MODE_RR) rr_ptr_q <= rr_target;
          end
        end
        StSend: begin
          if (accept) begin
            data_q <= in_data;
            tgt_q  <= next_tgt;
            cnt_q  <= '0;
            if (sched_mode == MODE_RR) rr_ptr_q <= rr_target;
          end else if (deliver) begin
            state_q     <= StIdle;
            dist_enable <= 1'b0;
            busy        <= 1'b0;
          end else if (timeout_hit) begin
            state_q     <= StIdle;
            dist_enable <= 1'b0;
            busy        <= 1'b0;
            drop_pulse  <= 1'b1;
          end else if (TIMEOUT != 0) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DIST_SCHED_STATS_EN
  logic [15:0] stat_cnt_q [NUM_CH];

  // Saturating per-channel delivery counters, global drop counter, registered readout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) stat_cnt_q[i] <= '0;
      stat_count <= '0;
      stat_drops <= '0;
    end else begin
      stat_count <= stat_cnt_q[stat_ch];
      if (deliver && (stat_cnt_q[tgt_q] != 16'hFFFF)) begin
        stat_cnt_q[tgt_q] <= stat_cnt_q[tgt_q] + 16'd1;
      end
      if (timeout_hit && (stat_drops != 16'hFFFF)) begin
        stat_drops <= stat_drops + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dist_scheduler.sv
// Self-checking bench for dist_scheduler: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_dist_scheduler;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              sched_mode = 1'b0;
  logic [1:0]        fixed_ch = '0;
  logic [3:0]        ch_mask = '0;
  logic [3:0]        ch_ready = '0;
  logic              dist_enable;
  logic [1:0]        dist_select;
  logic [DATA_W-1:0] dist_data;
  logic              drop_pulse;
  logic              busy;
`ifdef DIST_SCHED_STATS_EN
  logic [1:0]        stat_ch = '0;
  logic [15:0]       stat_count;
  logic [15:0]       stat_drops;
`endif

  dist_scheduler #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .sched_mode  (sched_mode),
    .fixed_ch    (fixed_ch),
    .ch_mask     (ch_mask),
    .ch_ready    (ch_ready),
    .dist_enable (dist_enable),
    .dist_select (dist_select),
    .dist_data   (dist_data),
    .drop_pulse  (drop_pulse),
    .busy        (busy)
`ifdef DIST_SCHED_STATS_EN
    ,
    .stat_ch     (stat_ch),
    .stat_count  (stat_count),
    .stat_drops  (stat_drops)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one held beat, its channel, its byte, cycles waited, and the rr pointer.
  bit          m_held = 0;
  int          m_tgt = 0;
  logic [7:0]  m_data = '0;
  int          m_wait = 0;
  int          m_ptr = 3;
  bit          m_drop = 0;
  int          m_cnt [4] = '{0, 0, 0, 0};
  int          m_drops = 0;
  int          m_stat_exp = 0;

  function automatic int rr_pick(int ptr, logic [3:0] mask);
    for (int off = 1; off <= 4; off++) begin
      int c;
      c = (ptr + off) % 4;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit m_in_ready();
    bit ex;
    ex = sched_mode || (ch_mask != 4'h0);
    if (!rst_n) return 1'b0;
    if (!m_held) return ex;
    return ch_ready[m_tgt] && ex;
  endfunction

  // Advance the model across the coming clock edge using the inputs now applied.
  task automatic model_step();
    bit acc, dlv, drp;
    int t;
    if (!rst_n) begin
      m_held = 0; m_ptr = 3; m_drop = 0; m_wait = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_drops = 0; m_stat_exp = 0;
      return;
    end
    acc = in_valid && m_in_ready();
    dlv = m_held && ch_ready[m_tgt];
    drp = m_held && !ch_ready[m_tgt] && (TIMEOUT != 0) && (m_wait + 1 == TIMEOUT);
`ifdef DIST_SCHED_STATS_EN
    m_stat_exp = m_cnt[stat_ch];
`endif
    if (dlv && m_cnt[m_tgt] < 65535) m_cnt[m_tgt]++;
    if (drp && m_drops < 65535) m_drops++;
    m_drop = drp;
    if (acc) begin
      t = sched_mode ? int'(fixed_ch) : rr_pick(m_ptr, ch_mask);
      if (!sched_mode) m_ptr = t;
      m_held = 1; m_tgt = t; m_data = in_data; m_wait = 0;
    end else if (dlv || drp) begin
      m_held = 0;
    end else if (m_held) begin
      m_wait++;
    end
  endtask

  task automatic next_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; ch_mask = 4'hF; ch_ready = 4'hF; in_data = 8'h99;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++; $display("FAIL reset_in_ready got %0b want 0", in_ready);
      end
      next_cycle();
    end
    rst_n = 1; in_valid = 0;
    @(negedge clk);
    n_cmp++;
    if ({dist_enable, dist_select, dist_data, drop_pulse, busy} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got en=%0b sel=%0d data=%h drop=%0b busy=%0b want all 0",
               dist_enable, dist_select, dist_data, drop_pulse, busy);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_ready got %0b want 1", in_ready);
    end
`ifdef DIST_SCHED_STATS_EN
    n_cmp++;
    if (stat_count !== 16'd0 || stat_drops !== 16'd0) begin
      n_bad++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_count, stat_drops);
    end
`endif
    next_cycle();
  endtask

  task automatic test_rr_stream();
    logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    sched_mode = 0; ch_mask = 4'hF; ch_ready = 4'hF;
    for (int k = 0; k <= 5; k++) begin
      in_valid = (k < 5);
      in_data  = (k < 5) ? bytes[k] : 8'h00;
      @(negedge clk);
      if (k < 5) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_bad++; $display("FAIL rr_stream_ready k=%0d got %0b want 1", k, in_ready);
        end
      end
      if (k > 0) begin
        n_cmp++;
        if (dist_enable !== 1'b1 || dist_select !== 2'((k - 1) % 4) || dist_data !== bytes[k-1])
        begin
          n_bad++;
          $display("FAIL rr_stream_out k=%0d got en=%0b sel=%0d data=%h want 1/%0d/%h",
                   k, dist_enable, dist_select, dist_data, (k - 1) % 4, bytes[k-1]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_rr_mask();
    int exp_sel [3] = '{1, 3, 1};
    sched_mode = 0; ch_mask = 4'b1010; ch_ready = 4'hF;
    for (int k = 0; k <= 3; k++) begin
      in_valid = (k < 3);
      in_data  = 8'(8'hB0 + k);
      @(negedge clk);
      if (k > 0) begin
        n_cmp++;
        if (dist_enable !== 1'b1 || dist_select !== 2'(exp_sel[k-1])) begin
          n_bad++;
          $display("FAIL rr_mask_sel k=%0d got en=%0b sel=%0d want 1/%0d",
                   k, dist_enable, dist_select, exp_sel[k-1]);
        end
      end
      next_cycle();
    end
    ch_mask = 4'b0000; in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0 || dist_enable !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_mask_zero got rdy=%0b en=%0b want 0/0", in_ready, dist_enable);
      end
      next_cycle();
    end
    in_valid = 0;
  endtask

  task automatic test_fixed_hold();
    sched_mode = 1; fixed_ch = 2; ch_mask = 4'h0; ch_ready = 4'b1011;
    in_valid = 1; in_data = 8'hA5;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL fixed_accept_ready got %0b want 1", in_ready);
    end
    next_cycle();
    in_valid = 0;
    for (int s = 1; s <= 6; s++) begin
      if (s == 6) ch_ready = 4'hF;
      @(negedge clk);
      n_cmp++;
      if (dist_enable !== 1'b1 || dist_select !== 2'd2 || dist_data !== 8'hA5 ||
          drop_pulse !== 1'b0) begin
        n_bad++;
        $display("FAIL fixed_hold s=%0d got en=%0b sel=%0d data=%h drop=%0b want 1/2/a5/0",
                 s, dist_enable, dist_select, dist_data, drop_pulse);
      end
      n_cmp++;
      if (in_ready !== (s == 6)) begin
        n_bad++; $display("FAIL fixed_ready s=%0d got %0b want %0b", s, in_ready, s == 6);
      end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++;
    if (dist_enable !== 1'b0 || drop_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL fixed_done got en=%0b drop=%0b want 0/0", dist_enable, drop_pulse);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    sched_mode = 1; fixed_ch = 1; ch_ready = 4'h0; in_valid = 1; in_data = 8'h5A;
    next_cycle();
    in_valid = 0;
    for (int s = 1; s <= 18; s++) begin
      @(negedge clk);
      n_cmp++;
      if (s <= 16) begin
        if (dist_enable !== 1'b1 || drop_pulse !== 1'b0) begin
          n_bad++;
          $display("FAIL timeout_wait s=%0d got en=%0b drop=%0b want 1/0",
                   s, dist_enable, drop_pulse);
        end
      end else if (s == 17) begin
        if (drop_pulse !== 1'b1 || dist_enable !== 1'b0 || busy !== 1'b0) begin
          n_bad++;
          $display("FAIL timeout_drop got drop=%0b en=%0b busy=%0b want 1/0/0",
                   drop_pulse, dist_enable, busy);
        end
      end else begin
        if (drop_pulse !== 1'b0) begin
          n_bad++; $display("FAIL timeout_pulse_width got drop=%0b want 0", drop_pulse);
        end
      end
      next_cycle();
    end
    in_valid = 1; in_data = 8'h6B;
    next_cycle();
    in_valid = 0;
    for (int s = 1; s <= 18; s++) begin
      ch_ready = (s == 16) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      n_cmp++;
      if (s <= 16) begin
        if (dist_enable !== 1'b1 || drop_pulse !== 1'b0 || dist_data !== 8'h6B) begin
          n_bad++;
          $display("FAIL late_ready_wait s=%0d got en=%0b drop=%0b data=%h want 1/0/6b",
                   s, dist_enable, drop_pulse, dist_data);
        end
      end else if (dist_enable !== 1'b0 || drop_pulse !== 1'b0) begin
        n_bad++;
        $display("FAIL late_ready_deliver s=%0d got en=%0b drop=%0b want 0/0",
                 s, dist_enable, drop_pulse);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = 8'($urandom);
      sched_mode = ($urandom_range(0, 3) == 0);
      fixed_ch   = 2'($urandom);
      ch_mask    = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      ch_ready   = ((c % 80) < 20) ? 4'h0 : 4'($urandom);
`ifdef DIST_SCHED_STATS_EN
      stat_ch    = 2'($urandom);
`endif
      @(negedge clk);
      n_cmp++;
      if (in_ready !== m_in_ready()) begin
        n_bad++; $display("FAIL rand_ready c=%0d got %0b want %0b", c, in_ready, m_in_ready());
      end
      n_cmp++;
      if (dist_enable !== m_held || busy !== m_held || drop_pulse !== m_drop) begin
        n_bad++;
        $display("FAIL rand_ctrl c=%0d got en=%0b busy=%0b drop=%0b want %0b/%0b/%0b",
                 c, dist_enable, busy, drop_pulse, m_held, m_held, m_drop);
      end
      if (m_held) begin
        n_cmp++;
        if (dist_select !== 2'(m_tgt) || dist_data !== m_data) begin
          n_bad++;
          $display("FAIL rand_beat c=%0d got sel=%0d data=%h want %0d/%h",
                   c, dist_select, dist_data, m_tgt, m_data);
        end
      end
`ifdef DIST_SCHED_STATS_EN
      n_cmp++;
      if (stat_count !== 16'(m_stat_exp) || stat_drops !== 16'(m_drops)) begin
        n_bad++;
        $display("FAIL rand_stats c=%0d got cnt=%0d drops=%0d want %0d/%0d",
                 c, stat_count, stat_drops, m_stat_exp, m_drops);
      end
`endif
      next_cycle();
    end
    in_valid = 0; ch_ready = 4'hF;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_mid_send();
    sched_mode = 1; fixed_ch = 3; ch_ready = 4'h0; in_valid = 1; in_data = 8'hC3;
    next_cycle();
    in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || dist_select !== 2'd3) begin
        n_bad++;
        $display("FAIL midsend_hold got busy=%0b sel=%0d want 1/3", busy, dist_select);
      end
      next_cycle();
    end
    rst_n = 0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL midsend_rst_ready got %0b want 0", in_ready);
    end
    next_cycle();
    rst_n = 1; sched_mode = 0; ch_mask = 4'hF; ch_ready = 4'hF; in_valid = 1; in_data = 8'h77;
    @(negedge clk);
    n_cmp++;
    if ({dist_enable, dist_select, dist_data, drop_pulse, busy} !== 13'd0) begin
      n_bad++;
      $display("FAIL midsend_reset_out got en=%0b sel=%0d data=%h drop=%0b busy=%0b want 0",
               dist_enable, dist_select, dist_data, drop_pulse, busy);
    end
`ifdef DIST_SCHED_STATS_EN
    n_cmp++;
    if (stat_count !== 16'd0 || stat_drops !== 16'd0) begin
      n_bad++; $display("FAIL midsend_stats got %0d/%0d want 0/0", stat_count, stat_drops);
    end
`endif
    next_cycle();
    in_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (dist_enable !== 1'b1 || dist_select !== 2'd0 || dist_data !== 8'h77) begin
      n_bad++;
      $display("FAIL post_reset_first got en=%0b sel=%0d data=%h want 1/0/77",
               dist_enable, dist_select, dist_data);
    end
    next_cycle();
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_rr_stream();
    test_rr_mask();
    test_fixed_hold();
    test_timeout();
    test_random();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dist_scheduler.md
# dist_scheduler

- Sequences the 4-way byte distributor: accepts a stream of bytes on a valid/ready input and decides which output channel each byte goes to.
- Drives the distributor's `enable`, `select_line` and `input_data` from registers, so the distributor outputs are glitch-free.
- Supports round-robin over a channel mask or a fixed target channel, with per-beat delivery handshakes and a stall timeout that drops stuck beats.
- Sits between the upstream byte source and the distributor in the distribution datapath.

## Interface
Parameters:
- `DATA_W`, 8, byte width; must match the distributor data width.
- `TIMEOUT`, 16, max SEND cycles waiting on `ch_ready` before a drop; 0 disables the timeout. Range 0..255.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  upstream byte valid.
- `in_ready`  out  1  scheduler can accept a byte this cycle.
- `in_data`  in  DATA_W  upstream byte.
- `sched_mode`  in  1  0 = round-robin over `ch_mask`, 1 = fixed channel.
- `fixed_ch`  in  2  target channel when `sched_mode`=1.
- `ch_mask`  in  4  channels eligible for round-robin.
- `ch_ready`  in  4  per-channel sink ready.
- `dist_enable`  out  1  to distributor `enable`.
- `dist_select`  out  2  to distributor `select_line`.
- `dist_data`  out  DATA_W  to distributor `input_data`.
- `drop_pulse`  out  1  one-cycle pulse when a beat is dropped on timeout.
- `busy`  out  1  high while a beat is held (SEND).

## Operation
FSM states:
- IDLE: no beat is held.
  - `in_ready` = 1 if a target exists: `sched_mode`=1, or `ch_mask`≠0.
  - On `in_valid && in_ready`: latch `in_data`, latch the target channel, clear the timeout counter, go to SEND.
- SEND: holds the beat. `dist_enable`=1, `dist_select`=target, `dist_data`=latched byte.
  - If `ch_ready[target]`=1, the beat is delivered this cycle.
  - `in_ready` = `ch_ready[target]` && target exists, so a new byte can be accepted in the same cycle (back-to-back transfer).
  - On delivery with a new accept: stay in SEND with the new byte and target.
  - On delivery without a new accept: go to IDLE.
  - If `ch_ready[target]`=0: increment the timeout counter.
  - If the counter equals TIMEOUT-1 and `ch_ready[target]`=0 (and TIMEOUT≠0): drop the beat and go to IDLE.

Target selection (evaluated at accept time only):
- Fixed mode: target = `fixed_ch`; `ch_mask` is ignored.
- Round-robin: target = the first channel set in `ch_mask`, searching upward from `rr_ptr`+1 modulo 4.
  - `rr_ptr` updates to the target on accept.
  - Fixed-mode accepts do not move `rr_ptr`.

Boundary rules:
- `ch_mask`, `sched_mode` and `fixed_ch` changing while a beat is in SEND do not retarget the held beat.
- `ch_ready` on non-target channels is ignored.
- Ready arriving on the final timeout cycle wins: the beat is delivered and no drop occurs.

## Timing
- Reset values: state IDLE, `dist_enable`=0, `dist_select`=0, `dist_data`=0, `drop_pulse`=0, `busy`=0, `rr_ptr`=3 (first round-robin grant is channel 0), timeout counter 0.
- `in_ready` is 0 while `rst_n`=0.
- Latency: byte accepted at cycle N appears on the `dist_*` outputs at cycle N+1.
- Throughput: one byte per cycle when the target channel's `ch_ready` is held high.
- `drop_pulse` is asserted in the cycle after the final timeout cycle; `dist_enable` is 0 in that same cycle.
- `in_ready` depends combinationally on state, `ch_mask`, `sched_mode` and `ch_ready`. `dist_*` outputs never depend combinationally on `ch_ready`.
- Reset mid-SEND: the held beat is discarded with no `drop_pulse`, and all outputs take their reset values at the next edge.

## Configuration
`DIST_SCHED_STATS_EN`:
- Defined: adds input `stat_ch`[1:0] and outputs `stat_count`[15:0] and `stat_drops`[15:0].
  - `stat_count` shows the delivered-beat count of channel `stat_ch`.
  - `stat_drops` counts timeout drops across all channels.
  - All counters saturate at 16'hFFFF and reset to 0.
  - The displayed `stat_count` is registered, valid one cycle after `stat_ch` changes.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Package `dist_pkg`:
  - state enum (IDLE, SEND);
  - `NUM_CH`=4 and `CH_W`=2;
  - mode constants `MODE_RR`=0 and `MODE_FIXED`=1.
- Sub-module `dist_rr_pick`: combinational round-robin picker. Inputs: mask, ptr. Outputs: target, any. Used by the FSM in round-robin mode.

## Test plan
- Round-robin, `ch_mask`=4'b1111, `ch_ready`=4'hF, bytes 0x11,0x22,0x33,0x44,0x55 streamed continuously → `dist_select` = 0,1,2,3,0 on consecutive cycles, starting one cycle after the first accept; no bubbles.
- Round-robin with `ch_mask`=4'b1010 → targets alternate 1,3,1; `ch_mask`=0 → `in_ready`=0 and `dist_enable`=0.
- Fixed mode with `fixed_ch`=2, `ch_ready[2]` low for 5 cycles then high → 0xA5 held on `dist_data` with `dist_select`=2 for 6 cycles; delivered, no drop.
- TIMEOUT=16, target never ready → `drop_pulse` for one cycle 17 cycles after the accept, then IDLE; with ready arriving exactly on the 16th SEND cycle → delivered, no pulse.
- Reset asserted mid-SEND → next cycle all outputs at reset values; the first byte after reset goes to channel 0. With `DIST_SCHED_STATS_EN` defined, all counters read 0 after reset and `stat_count` increments per delivery.
